// File: rtl/te_pkg.sv
// Shared types and constants for the trace encoder's branch map sequencing.
package te_pkg;

  localparam int BRANCH_COUNT_LEN = 5;
  localparam int BRANCH_MAP_MAX   = 31;

  // Encoding is externally visible on pkt_reason_o.
  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    DISC    = 2'd1,
    FULL    = 2'd2,
    TIMEOUT = 2'd3
  } bmap_reason_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } bmap_ctrl_state_e;

endpackage

// File: rtl/te_bmap_timeout.sv
// Idle-timeout detector: counts cycles a non-empty, unchanged branch map sits in IDLE.
// Instantiated only when TE_BRANCH_MAP_TIMEOUT_EN is defined.
module te_bmap_timeout
  import te_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        count_en_i,
  input  logic                        clear_i,
  input  logic [BRANCH_COUNT_LEN-1:0] branches_i,
  input  logic                        is_empty_i,
  output logic                        hit_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [BRANCH_COUNT_LEN-1:0] prev_q;
  logic [CNT_W-1:0]            cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= branches_i;
      if (clear_i || is_empty_i || (branches_i != prev_q)) begin
        cnt_q <= '0;
      end else if (count_en_i && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign hit_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/te_branch_map_ctrl.sv
// Branch map emission sequencer: IDLE -> REQ (valid/ready) -> FLUSH, with sticky pending
// sync/discontinuity requests. Optional idle timeout under TE_BRANCH_MAP_TIMEOUT_EN.
module te_branch_map_ctrl
  import te_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [BRANCH_COUNT_LEN-1:0] branches_i,
  input  logic                        is_full_i,
  input  logic                        is_empty_i,
  input  logic                        discontinuity_i,
  input  logic                        sync_req_i,
  input  logic                        pkt_ready_i,
  output logic                        pkt_valid_o,
  output logic [1:0]                  pkt_reason_o,
  output logic [BRANCH_COUNT_LEN-1:0] pkt_branches_o,
  output logic                        flush_o,
  output logic                        busy_o
);

  bmap_ctrl_state_e            state_q, state_d;
  bmap_reason_e                reason_q, reason_d, start_reason;
  logic [BRANCH_COUNT_LEN-1:0] branches_q, branches_d;
  logic                        pend_sync_q, pend_sync_d;
  logic                        pend_disc_q, pend_disc_d;
  logic                        start;
  logic                        timeout_hit;

`ifdef TE_BRANCH_MAP_TIMEOUT_EN
  te_bmap_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .count_en_i (state_q == IDLE),
    .clear_i    (flush_o),
    .branches_i (branches_i),
    .is_empty_i (is_empty_i),
    .hit_o      (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    reason_d     = reason_q;
    branches_d   = branches_q;
    pend_sync_d  = pend_sync_q | sync_req_i;
    pend_disc_d  = pend_disc_q | discontinuity_i;
    start        = 1'b0;
    start_reason = SYNC;

    case (state_q)
      IDLE: begin
        if (pend_sync_d) begin
          start        = 1'b1;
          start_reason = SYNC;
          pend_sync_d  = 1'b0;
        end else if (pend_disc_d) begin
          start        = 1'b1;
          start_reason = DISC;
          pend_disc_d  = 1'b0;
        end else if (is_full_i) begin
          start        = 1'b1;
          start_reason = FULL;
        end else if (timeout_hit) begin
          start        = 1'b1;
          start_reason = TIMEOUT;
        end
      end
      REQ: begin
        if (pkt_ready_i) state_d = FLUSH;
      end
      FLUSH: begin
        // Pending requests chain straight into the next REQ; full/timeout wait for IDLE.
        state_d = IDLE;
        if (pend_sync_d) begin
          start        = 1'b1;
          start_reason = SYNC;
          pend_sync_d  = 1'b0;
        end else if (pend_disc_d) begin
          start        = 1'b1;
          start_reason = DISC;
          pend_disc_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = REQ;
      reason_d   = start_reason;
      branches_d = is_empty_i ? '0 : branches_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      reason_q    <= SYNC;
      branches_q  <= '0;
      pend_sync_q <= 1'b0;
      pend_disc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      reason_q    <= reason_d;
      branches_q  <= branches_d;
      pend_sync_q <= pend_sync_d;
      pend_disc_q <= pend_disc_d;
    end
  end

  assign pkt_valid_o    = (state_q == REQ);
  assign flush_o        = (state_q == FLUSH);
  assign busy_o         = (state_q != IDLE);
  assign pkt_reason_o   = reason_q;
  assign pkt_branches_o = branches_q;

endmodule

// File: tb/tb_te_branch_map_ctrl.sv
// Scoreboard bench for te_branch_map_ctrl: directed triggers push expected requests,
// a negedge monitor checks every presented request and every flush pulse.
module tb_te_branch_map_ctrl;
  import te_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [BRANCH_COUNT_LEN-1:0] branches_i = '0;
  logic                        is_full_i = 1'b0;
  logic                        is_empty_i = 1'b1;
  logic                        discontinuity_i = 1'b0;
  logic                        sync_req_i = 1'b0;
  logic                        pkt_ready_i = 1'b0;
  logic                        pkt_valid_o;
  logic [1:0]                  pkt_reason_o;
  logic [BRANCH_COUNT_LEN-1:0] pkt_branches_o;
  logic                        flush_o;
  logic                        busy_o;

  typedef struct {
    logic [1:0]                  reason;
    logic [BRANCH_COUNT_LEN-1:0] branches;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic flush_exp = 1'b0;

  te_branch_map_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .branches_i      (branches_i),
    .is_full_i       (is_full_i),
    .is_empty_i      (is_empty_i),
    .discontinuity_i (discontinuity_i),
    .sync_req_i      (sync_req_i),
    .pkt_ready_i     (pkt_ready_i),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_reason_o    (pkt_reason_o),
    .pkt_branches_o  (pkt_branches_o),
    .flush_o         (flush_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_req(input bmap_reason_e r, input logic [BRANCH_COUNT_LEN-1:0] b);
    exp_t e;
    e.reason   = r;
    e.branches = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle a request is presented it must match the queue head; the head
  // retires on handshake, and exactly one flush pulse must follow each handshake.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      flush_exp = 1'b0;
    end else begin
      logic hs;
      hs = pkt_valid_o && pkt_ready_i;
      if (flush_o || flush_exp) check("flush_pulse", 32'(flush_o), 32'(flush_exp));
      if (pkt_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got reason %0d branches %0d expected no request at %0t",
                   pkt_reason_o, pkt_branches_o, $time);
        end else begin
          check("req_reason", 32'(pkt_reason_o), 32'(exp_q[0].reason));
          check("req_branches", 32'(pkt_branches_o), 32'(exp_q[0].branches));
          if (hs) void'(exp_q.pop_front());
        end
      end
      flush_exp = hs;
    end
  end

  initial begin
    #3;
    check("rst_valid", 32'(pkt_valid_o), 0);
    check("rst_flush", 32'(flush_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_reason", 32'(pkt_reason_o), 0);
    check("rst_branches", 32'(pkt_branches_o), 0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Full map, emitter stalls five cycles.
    branches_i = 5'd31; is_full_i = 1'b1; is_empty_i = 1'b0; pkt_ready_i = 1'b0;
    expect_req(FULL, 5'd31);
    tick();
    check("full_valid_rise", 32'(pkt_valid_o), 1);
    for (int i = 0; i < 5; i++) tick();
    pkt_ready_i = 1'b1;
    tick();
    check("full_flush", 32'(flush_o), 1);
    branches_i = '0; is_full_i = 1'b0; is_empty_i = 1'b1; pkt_ready_i = 1'b0;
    tick();
    check("full_busy_after", 32'(busy_o), 0);
    tick();

    // Discontinuity with a non-empty map, ready tied high.
    branches_i = 5'd7; is_empty_i = 1'b0; pkt_ready_i = 1'b1;
    discontinuity_i = 1'b1;
    expect_req(DISC, 5'd7);
    tick();
    discontinuity_i = 1'b0;
    check("disc_valid", 32'(pkt_valid_o), 1);
    tick();
    check("disc_flush", 32'(flush_o), 1);
    branches_i = '0; is_empty_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("disc_idle", 32'(busy_o), 0);

    // Simultaneous sync + disc, then two more disc pulses while the request stalls.
    branches_i = 5'd4; is_empty_i = 1'b0; pkt_ready_i = 1'b0;
    sync_req_i = 1'b1; discontinuity_i = 1'b1;
    expect_req(SYNC, 5'd4);
    tick();
    sync_req_i = 1'b0; discontinuity_i = 1'b0;
    branches_i = 5'd9;
    discontinuity_i = 1'b1;
    tick();
    discontinuity_i = 1'b0;
    tick();
    discontinuity_i = 1'b1;
    tick();
    discontinuity_i = 1'b0;
    pkt_ready_i = 1'b1;
    tick();
    check("prio_flush", 32'(flush_o), 1);
    branches_i = 5'd2;
    expect_req(DISC, 5'd2);
    tick();
    check("pend_valid", 32'(pkt_valid_o), 1);
    tick();
    branches_i = '0; is_empty_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("pend_single", 32'(busy_o), 0);

    // Discontinuity on an empty map.
    pkt_ready_i = 1'b1; discontinuity_i = 1'b1;
    expect_req(DISC, 5'd0);
    tick();
    discontinuity_i = 1'b0;
    tick();
    check("empty_flush", 32'(flush_o), 1);
    tick();
    tick();

    // Idle timeout.
    pkt_ready_i = 1'b0; branches_i = 5'd3; is_empty_i = 1'b0;
`ifdef TE_BRANCH_MAP_TIMEOUT_EN
    for (int i = 0; i < 10; i++) tick();
    branches_i = 5'd5;
    for (int i = 0; i < 16; i++) tick();
    check("tmo_not_yet", 32'(busy_o), 0);
    expect_req(TIMEOUT, 5'd5);
    tick();
    check("tmo_valid", 32'(pkt_valid_o), 1);
    pkt_ready_i = 1'b1;
    tick();
    check("tmo_flush", 32'(flush_o), 1);
    pkt_ready_i = 1'b0;
`else
    for (int i = 0; i < 40; i++) tick();
    check("tmo_absent", 32'(busy_o), 0);
`endif
    branches_i = '0; is_empty_i = 1'b1;
    tick();
    tick();

    // Reset while a request is pending, with a pending disc latched.
    branches_i = 5'd6; is_empty_i = 1'b0; pkt_ready_i = 1'b0;
    sync_req_i = 1'b1;
    expect_req(SYNC, 5'd6);
    tick();
    sync_req_i = 1'b0; discontinuity_i = 1'b1;
    tick();
    discontinuity_i = 1'b0;
    check("prerst_valid", 32'(pkt_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", 32'(pkt_valid_o), 0);
    check("midrst_flush", 32'(flush_o), 0);
    check("midrst_busy", 32'(busy_o), 0);
    exp_q.delete();
    branches_i = '0; is_empty_i = 1'b1; pkt_ready_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("postrst_flush", 32'(flush_o), 0);
    end
    check("postrst_busy", 32'(busy_o), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
